// File: rtl/note_tone_if.sv
// Note-code bus between a note source (master) and the tone generator (slave).
interface note_tone_if;
  logic       en;
  logic [4:0] note_code;
  logic       tone;
  logic       playing;
  logic [4:0] cur_note;

  modport master (output en, note_code, input tone, playing, cur_note);
  modport slave  (input en, note_code, output tone, playing, cur_note);
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator driven by a 5-bit note code; pitch changes land on period boundaries.
// Optional macro TONE_DUTY25_EN selects a 25% duty cycle instead of 50%.
module note_tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 24
) (
  input  logic clk,
  input  logic rst_n,
  note_tone_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             tone_q;
  logic             playing_q;
  logic [4:0]       cur_q;

  logic [CNT_W-1:0] per;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] cnt_nxt;
  logic             valid;

  assign valid   = bus.en && (bus.note_code >= 5'd1) && (bus.note_code <= 5'd20);
  assign cnt_nxt = cnt + 1'b1;

  // Constant divisions only; each arm folds to a literal at elaboration.
  always_comb begin
    per = '0;
    case (cur_q)
      5'd1:  per = CNT_W'(CLK_HZ / 262);
      5'd2:  per = CNT_W'(CLK_HZ / 294);
      5'd3:  per = CNT_W'(CLK_HZ / 330);
      5'd4:  per = CNT_W'(CLK_HZ / 349);
      5'd5:  per = CNT_W'(CLK_HZ / 392);
      5'd6:  per = CNT_W'(CLK_HZ / 440);
      5'd7:  per = CNT_W'(CLK_HZ / 494);
      5'd8:  per = CNT_W'(CLK_HZ / 523);
      5'd9:  per = CNT_W'(CLK_HZ / 587);
      5'd10: per = CNT_W'(CLK_HZ / 659);
      5'd11: per = CNT_W'(CLK_HZ / 698);
      5'd12: per = CNT_W'(CLK_HZ / 784);
      5'd13: per = CNT_W'(CLK_HZ / 880);
      5'd14: per = CNT_W'(CLK_HZ / 988);
      5'd15: per = CNT_W'(CLK_HZ / 1047);
      5'd16: per = CNT_W'(CLK_HZ / 1175);
      5'd17: per = CNT_W'(CLK_HZ / 1319);
      5'd18: per = CNT_W'(CLK_HZ / 1397);
      5'd19: per = CNT_W'(CLK_HZ / 1568);
      5'd20: per = CNT_W'(CLK_HZ / 1760);
      default: per = '0;
    endcase
  end

`ifdef TONE_DUTY25_EN
  assign hi_len = per >> 2;
`else
  assign hi_len = per >> 1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tone_q    <= 1'b0;
      playing_q <= 1'b0;
      cur_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (valid) begin
            cur_q     <= bus.note_code;
            tone_q    <= 1'b1;
            playing_q <= 1'b1;
            state     <= RUN;
          end else begin
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            cur_q     <= '0;
          end
        end
        RUN: begin
          // Dropping en mutes immediately, even mid-period.
          if (!bus.en) begin
            cnt       <= '0;
            tone_q    <= 1'b0;
            playing_q <= 1'b0;
            cur_q     <= '0;
            state     <= IDLE;
          end else if (cnt == per - 1'b1) begin
            cnt <= '0;
            if (valid) begin
              cur_q  <= bus.note_code;
              tone_q <= 1'b1;
            end else begin
              tone_q    <= 1'b0;
              playing_q <= 1'b0;
              cur_q     <= '0;
              state     <= IDLE;
            end
          end else begin
            cnt    <= cnt_nxt;
            tone_q <= (cnt_nxt < hi_len);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tone     = tone_q;
  assign bus.playing  = playing_q;
  assign bus.cur_note = cur_q;

endmodule
